des_decrypt_core: RTL and testbench
===================================

// Module: des_decrypt_core
// PURPOSE
//  Iterative DES decryption engine; inverse-direction partner of the encryption datapath.
//  Takes a 64-bit ciphertext block and a 64-bit key.
//  Runs 16 Feistel rounds with subkeys generated on the fly in reverse order (K16..K1).
//  Returns the 64-bit plaintext over a valid/ready stream interface.
//  Sits between the link receive buffer and the decompression stage.
// PARAMETERS
//  UNROLL  1  Feistel rounds per clock; legal values 1, 2, 4; latency = 16/UNROLL cycles
// PORTS
//  Clocking: one clock; reset is synchronous and active-high.
//  clk       in   1   system clock, rising edge
//  rst       in   1   synchronous active-high reset
//  in_valid  in   1   ciphertext/key presented
//  in_ready  out  1   core can accept a block (IDLE only)
//  data_in   in   64  ciphertext, bit 63 = DES bit 1
//  key_in    in   64  DES key incl. parity bits (parity ignored)
//  out_valid out  1   plaintext available
//  out_ready in   1   downstream accepts plaintext
//  data_out  out  64  plaintext, bit 63 = DES bit 1
//  busy      out  1   high in ROUND or DONE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1, out_valid=0, busy=0, data_out=0; all round/key registers cleared.
//  FSM states: IDLE, ROUND, DONE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&&in_ready: L,R <= IP(data_in); C,D <= PC1(key_in).
//   - round counter <= 0; go to ROUND.
//  ROUND: each cycle performs UNROLL steps; step j = 1..16 does:
//   - K = PC2(C,D)
//   - L' = R; R' = L ^ f(R,K)
//   - C,D rotate right by SHIFT[17-j], with SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
//     Step 1 therefore uses K16 = PC2(PC1(key)), since the total left shift is 28.
//   - After step 16: data_out <= FP({R16,L16}) (final swap); go to DONE.
//  ROUND: in_ready=0; in_valid is ignored and data_in/key_in may change freely.
//  DONE:
//   - out_valid=1; data_out is held stable until out_ready.
//   - On out_valid&&out_ready: out_valid<=0; go to IDLE.
//  Latency: accept edge to out_valid high = 16/UNROLL + 1 cycles.
//  Throughput: one block per 16/UNROLL + 2 cycles with out_ready tied high.
//  No accept in the cycle out_valid drops; the next block is accepted in the following IDLE cycle.
//  Backpressure: DONE may last any number of cycles; state, data_out and out_valid are unchanged.
//  Reset mid-operation (ROUND or DONE):
//   - Next cycle is IDLE with reset values; the partial block is discarded.
//   - out_valid never pulses for the discarded block.
//  f(R,K) = P(S1..S8(E(R) ^ K)).
//   - S-box row = outer bits b5,b0; column = inner bits b4..b1 of each 6-bit group.
//   - Purely combinational, within one cycle per step.
//  Round counter is 5 bits. With UNROLL not in {1,2,4}: elaboration $error.
// STRUCTURE
//  des_pkg:
//   - IP, FP, E, P, PC1, PC2 permutation tables as constant arrays
//   - SHIFT table
//   - 8x64 S-box constant table
//   - state enum {IDLE, ROUND, DONE}
//   - ROUNDS = 16
//  Sub-module des_f_function (R[31:0], K[47:0] -> f[31:0]), combinational.
//   - Instantiated UNROLL times in a generate loop, chained with the per-step key logic.
//  Top holds FSM, counter, L/R/C/D registers, and IP/FP/PC1 wiring.
// TESTING
//  1. FIPS vector, UNROLL=1, key 133457799BBCDFF1, data_in 85E813540F0AB405
//     -> data_out 0123456789ABCDEF, out_valid exactly 17 cycles after accept.
//  2. key 0E329232EA6D0D73, data_in 0000000000000000
//     -> data_out 8787878787878787; repeat for UNROLL=2 (latency 9) and UNROLL=4 (latency 5).
//  3. Backpressure: out_ready low for 10 cycles in DONE
//     -> out_valid and data_out stable, in_ready=0 throughout; released on the out_ready cycle.
//  4. Back-to-back blocks with in_valid and out_ready held high
//     -> accepts spaced 18 cycles (UNROLL=1); both plaintexts correct and in order.
//  5. Inputs changed and in_valid pulsed during ROUND -> ignored; result matches the originally accepted block.
//  6. rst asserted at round 7, then a new block sent
//     -> no out_valid for the aborted block; next block decrypts correctly with the nominal latency.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: shared tables, types and permutation helpers for the DES decryption core.
// Bit numbering convention: DES bit 1 is the MSB of every vector.
// Each permutation helper builds its output MSB-first: output bit n takes
// input bit TBL[n] (both counted from the MSB, 1-based, as in the DES tables).
package des_pkg;

  localparam int unsigned ROUNDS = 16;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  localparam int unsigned IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,  60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,  64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int unsigned FP_TBL [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25
  };

  localparam int unsigned E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
  };

  localparam int unsigned P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int unsigned PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
  };

  // Left-shift schedule of the encryption key schedule; decryption walks it backwards.
  localparam int unsigned SHIFT_TBL [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  // Row-major per box: entry index = row*16 + column.
  localparam int unsigned SBOX [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  function automatic logic [63:0] ip_perm(input logic [63:0] d);
    logic [63:0] o;
    logic [5:0]  idx;
    o = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      idx = 6'(64 - IP_TBL[i[5:0]]);
      o   = {o[62:0], d[idx]};
    end
    return o;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] d);
    logic [63:0] o;
    logic [5:0]  idx;
    o = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      idx = 6'(64 - FP_TBL[i[5:0]]);
      o   = {o[62:0], d[idx]};
    end
    return o;
  endfunction

  function automatic logic [47:0] e_perm(input logic [31:0] d);
    logic [47:0] o;
    logic [4:0]  idx;
    o = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      idx = 5'(32 - E_TBL[i[5:0]]);
      o   = {o[46:0], d[idx]};
    end
    return o;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] d);
    logic [31:0] o;
    logic [4:0]  idx;
    o = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      idx = 5'(32 - P_TBL[i[4:0]]);
      o   = {o[30:0], d[idx]};
    end
    return o;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] d);
    logic [55:0] o;
    logic [5:0]  idx;
    o = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      idx = 6'(64 - PC1_TBL[i[5:0]]);
      o   = {o[54:0], d[idx]};
    end
    return o;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] d);
    logic [47:0] o;
    logic [5:0]  idx;
    o = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      idx = 6'(56 - PC2_TBL[i[5:0]]);
      o   = {o[46:0], d[idx]};
    end
    return o;
  endfunction

endpackage

// File: rtl/des_f_function.sv
// des_f_function: combinational DES round function f(R,K) = P(S1..S8(E(R) ^ K)).
// Ports:
//   r  in  32  right half R (bit 31 = DES bit 1)
//   k  in  48  round subkey
//   f  out 32  round function result
module des_f_function
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);

  logic [47:0] x;
  logic [31:0] s;
  logic [5:0]  grp;
  logic [5:0]  sidx;

  assign x = e_perm(r) ^ k;

  always_comb begin
    s    = '0;
    grp  = '0;
    sidx = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      grp  = 6'(x >> (42 - 6 * b));
      // Row from the outer bits, column from the inner four.
      sidx = {grp[5], grp[0], grp[4:1]};
      s    = {s[27:0], 4'(SBOX[b[2:0]][sidx])};
    end
  end

  assign f = p_perm(s);

endmodule

// File: rtl/des_decrypt_core.sv
// des_decrypt_core: iterative DES decryption with on-the-fly reverse key schedule.
// UNROLL Feistel steps per clock (1, 2 or 4); ciphertext accepted in IDLE,
// plaintext presented in DONE until taken.
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   ciphertext/key presented
//   in_ready   out  1   high in IDLE only
//   data_in    in   64  ciphertext, bit 63 = DES bit 1
//   key_in     in   64  DES key incl. parity bits (parity ignored)
//   out_valid  out  1   plaintext available (DONE)
//   out_ready  in   1   downstream accepts plaintext
//   data_out   out  64  plaintext, bit 63 = DES bit 1
//   busy       out  1   high in ROUND or DONE
module des_decrypt_core
  import des_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] data_in,
  input  logic [63:0] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("des_decrypt_core: UNROLL must be 1, 2 or 4");
  end

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] dout_q, dout_d;

  // Feistel chain: each step block links to its predecessor by name rather than
  // through a shared array, so the chain never reads a vector it also drives.
  for (genvar s = 0; s < UNROLL; s++) begin : g_step
    logic [31:0] l_in, r_in, l_out, r_out, f_out;
    logic [27:0] c_in, d_in, c_out, d_out;
    logic [47:0] subkey;
    logic        rot2;

    if (s == 0) begin : g_head
      assign l_in = l_q;
      assign r_in = r_q;
      assign c_in = c_q;
      assign d_in = d_q;
    end else begin : g_link
      assign l_in = g_step[s-1].l_out;
      assign r_in = g_step[s-1].r_out;
      assign c_in = g_step[s-1].c_out;
      assign d_in = g_step[s-1].d_out;
    end

    assign subkey = pc2_perm({c_in, d_in});

    des_f_function u_f (
      .r (r_in),
      .k (subkey),
      .f (f_out)
    );

    assign l_out = r_in;
    assign r_out = l_in ^ f_out;

    // Step j = cnt+s+1 undoes the encryption shift of round 17-j (table index 16-j).
    assign rot2  = (SHIFT_TBL[4'(5'd15 - cnt_q - 5'(s))] == 2);
    assign c_out = rot2 ? {c_in[1:0], c_in[27:2]} : {c_in[0], c_in[27:1]};
    assign d_out = rot2 ? {d_in[1:0], d_in[27:2]} : {d_in[0], d_in[27:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          {l_d, r_d} = ip_perm(data_in);
          {c_d, d_d} = pc1_perm(key_in);
          cnt_d      = '0;
          state_d    = ROUND;
        end
      end
      ROUND: begin
        l_d   = g_step[UNROLL-1].l_out;
        r_d   = g_step[UNROLL-1].r_out;
        c_d   = g_step[UNROLL-1].c_out;
        d_d   = g_step[UNROLL-1].d_out;
        cnt_d = cnt_q + 5'(UNROLL);
        if (cnt_q == 5'(ROUNDS - UNROLL)) begin
          dout_d  = fp_perm({g_step[UNROLL-1].r_out, g_step[UNROLL-1].l_out});
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      dout_q  <= dout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign data_out  = dout_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core: three instances (UNROLL 1, 2, 4) share
// clock, reset and data/key inputs; handshake signals are per instance.
module tb_des_decrypt_core;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2 = 64'h0000000000000000;
  localparam logic [63:0] P2 = 64'h8787878787878787;

  logic        clk;
  logic        rst;
  logic [63:0] data_in;
  logic [63:0] key_in;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [2:0]  busy;
  logic [63:0] dout [3];

  int checks = 0;
  int errors = 0;

  des_decrypt_core #(.UNROLL(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data_in), .key_in(key_in), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .data_out(dout[0]), .busy(busy[0])
  );

  des_decrypt_core #(.UNROLL(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data_in), .key_in(key_in), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .data_out(dout[1]), .busy(busy[1])
  );

  des_decrypt_core #(.UNROLL(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .data_in(data_in), .key_in(key_in), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .data_out(dout[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one block at a negedge, count negedges until out_valid, optionally
  // disturb inputs during ROUND, hold out_ready low for 'hold' cycles, then release.
  task automatic run_block(input logic [1:0] u, input logic [63:0] key, input logic [63:0] ct,
                           input logic [63:0] pt, input int lat_exp, input int hold,
                           input bit disturb, input string tag);
    int          lat;
    bit          ready_bad;
    logic [63:0] held;
    @(negedge clk);
    data_in     = ct;
    key_in      = key;
    in_valid[u] = 1'b1;
    out_ready[u] = 1'b0;
    check({tag, " accept_ready"}, 64'(in_ready[u]), 64'd1);
    lat       = 0;
    ready_bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (disturb && !out_valid[u]) begin
        data_in     = {$urandom(), $urandom()};
        key_in      = {$urandom(), $urandom()};
        in_valid[u] = lat[0];
      end else begin
        in_valid[u] = 1'b0;
      end
      if (!out_valid[u] && (in_ready[u] || !busy[u])) ready_bad = 1'b1;
    end while (!out_valid[u] && lat < 40);
    check({tag, " latency"}, 64'(lat), 64'(lat_exp));
    check({tag, " data"}, dout[u], pt);
    check({tag, " busy_not_ready"}, 64'(ready_bad), 64'd0);
    held = dout[u];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold_valid"}, 64'(out_valid[u]), 64'd1);
      check({tag, " hold_data"}, dout[u], held);
      check({tag, " hold_ready"}, 64'(in_ready[u]), 64'd0);
    end
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    check({tag, " release_valid"}, 64'(out_valid[u]), 64'd0);
    check({tag, " release_ready"}, 64'(in_ready[u]), 64'd1);
  endtask

  initial begin
    int          acc_cyc [2];
    logic [63:0] got [2];
    int          n_acc;
    int          n_out;
    bit          seen;

    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    data_in   = '0;
    key_in    = '0;
    repeat (3) @(negedge clk);
    check("rst in_ready", 64'(in_ready), 64'b111);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst data_out u1", dout[0], 64'd0);
    check("rst data_out u2", dout[1], 64'd0);
    check("rst data_out u4", dout[2], 64'd0);
    rst = 1'b0;

    run_block(2'd0, K1, C1, P1, 17, 0, 1'b0, "fips_u1");
    run_block(2'd0, K2, C2, P2, 17, 0, 1'b0, "k2_u1");
    run_block(2'd1, K2, C2, P2, 9, 0, 1'b0, "k2_u2");
    run_block(2'd2, K2, C2, P2, 5, 0, 1'b0, "k2_u4");
    run_block(2'd1, K1, C1, P1, 9, 0, 1'b0, "fips_u2");
    run_block(2'd2, K1, C1, P1, 5, 0, 1'b0, "fips_u4");
    run_block(2'd0, K1, C1, P1, 17, 10, 1'b0, "backpressure");
    run_block(2'd0, K2, C2, P2, 17, 0, 1'b1, "disturb");

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clk);
    data_in      = C1;
    key_in       = K1;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    n_acc = 0;
    n_out = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    got[0] = 'x;
    got[1] = 'x;
    for (int c = 0; c < 80; c++) begin
      if (in_ready[0] && n_acc < 2) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      if (out_valid[0]) begin
        got[n_out] = dout[0];
        n_out++;
      end
      if (n_out == 2) begin
        in_valid[0] = 1'b0;
        break;
      end
      @(negedge clk);
      if (n_acc == 1) begin
        data_in = C2;
        key_in  = K2;
      end
    end
    in_valid[0] = 1'b0;
    check("b2b outputs", 64'(n_out), 64'd2);
    check("b2b accepts", 64'(n_acc), 64'd2);
    check("b2b spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd18);
    check("b2b first", got[0], P1);
    check("b2b second", got[1], P2);
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("b2b idle", 64'(in_ready[0]), 64'd1);

    // Reset in the middle of ROUND.
    @(negedge clk);
    data_in     = C1;
    key_in      = K1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("abort busy_before", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", 64'(in_ready[0]), 64'd1);
    check("abort out_valid", 64'(out_valid[0]), 64'd0);
    check("abort busy", 64'(busy[0]), 64'd0);
    check("abort data_out", dout[0], 64'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    check("abort no_out_valid", 64'(seen), 64'd0);
    run_block(2'd0, K2, C2, P2, 17, 0, 1'b0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
